// File: rtl/rs_age_select.sv
// Age-ordered reservation station: multi-port wakeup, oldest-ready select, optional
// selective squash enabled by defining RS_SQUASH_EN (default build: flush-only recovery).
package rs_age_select_pkg;
    localparam int PREG_W    = 6;
    localparam int ROB_TAG_W = 4;
    localparam int OP_W      = 8;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [PREG_W-1:0] dst_tag;
        logic [PREG_W-1:0] src1_tag;
        logic              src1_rdy;
        logic [PREG_W-1:0] src2_tag;
        logic              src2_rdy;
    } rename_pkt_t;

    typedef struct packed {
        logic [OP_W-1:0]      opcode;
        logic [PREG_W-1:0]    dst_tag;
        logic [PREG_W-1:0]    src1_tag;
        logic [PREG_W-1:0]    src2_tag;
        logic [ROB_TAG_W-1:0] rob_tag;
    } issue_pkt_t;
endpackage

module rs_age_select
    import rs_age_select_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WAKE_PORTS = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush_i,
    input  logic                                 push_valid_i,
    output logic                                 push_ready_o,
    input  rename_pkt_t                          push_pkt_i,
    input  logic [ROB_TAG_W-1:0]                 push_rob_tag_i,
    input  logic [WAKE_PORTS-1:0]                wakeup_valid_i,
    input  logic [WAKE_PORTS-1:0][PREG_W-1:0]    wakeup_tag_i,
    input  logic [ROB_TAG_W-1:0]                 rob_head_i,
    input  logic                                 squash_valid_i,
    input  logic [ROB_TAG_W-1:0]                 squash_rob_tag_i,
    input  logic                                 exec_ready_i,
    output logic                                 issue_valid_o,
    output issue_pkt_t                           issue_pkt_o,
    output logic [CNT_W-1:0]                     count_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_src1_rdy;
    logic [DEPTH-1:0]     r_src2_rdy;
    rename_pkt_t          r_pkt [DEPTH];
    logic [ROB_TAG_W-1:0] r_rob [DEPTH];
    // r_age[i][j] set means entry j is older than entry i.
    logic [DEPTH-1:0]     r_age [DEPTH];
    logic [CNT_W-1:0]     r_count;

    logic [IDX_W-1:0]     w_free_idx;
    logic [DEPTH-1:0]     w_kill;
    logic                 w_push_drop;
    logic [DEPTH-1:0]     w_rdy;
    logic [DEPTH-1:0]     w_sel;
    logic [DEPTH-1:0]     w_issue_vec;
    logic                 w_issue_fire;
    logic                 w_push_fire;
    logic                 w_push_write;
    logic [CNT_W-1:0]     w_kill_cnt;
    logic [CNT_W-1:0]     w_count_nxt;

    function automatic logic wake_hit(
        input logic [PREG_W-1:0]                 tag,
        input logic [WAKE_PORTS-1:0]             vld,
        input logic [WAKE_PORTS-1:0][PREG_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            hit = hit | (vld[p] && (tags[p] == tag));
        end
        return hit && (tag != '0);
    endfunction

`ifdef RS_SQUASH_EN
    function automatic logic is_younger(
        input logic [ROB_TAG_W-1:0] tag,
        input logic [ROB_TAG_W-1:0] head,
        input logic [ROB_TAG_W-1:0] br
    );
        logic [ROB_TAG_W-1:0] tag_dist;
        logic [ROB_TAG_W-1:0] br_dist;
        tag_dist = tag - head;
        br_dist  = br - head;
        return tag_dist > br_dist;
    endfunction

    always_comb begin
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i] = squash_valid_i && r_valid[i]
                        && is_younger(r_rob[i], rob_head_i, squash_rob_tag_i);
        end
    end

    assign w_push_drop = squash_valid_i && is_younger(push_rob_tag_i, rob_head_i, squash_rob_tag_i);
`else
    logic w_unused_ok;
    assign w_kill      = '0;
    assign w_push_drop = 1'b0;
    assign w_unused_ok = &{1'b0, squash_valid_i, squash_rob_tag_i, rob_head_i};
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
    end

    // Entries being squashed are masked here so they are never offered.
    assign w_rdy = r_valid & r_src1_rdy & r_src2_rdy & ~w_kill;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = w_rdy[i] && ((r_age[i] & w_rdy) == '0);
        end
    end

    always_comb begin
        issue_pkt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                issue_pkt_o = '{opcode:   r_pkt[i].opcode,
                                dst_tag:  r_pkt[i].dst_tag,
                                src1_tag: r_pkt[i].src1_tag,
                                src2_tag: r_pkt[i].src2_tag,
                                rob_tag:  r_rob[i]};
            end
        end
    end

    assign issue_valid_o = |w_sel;
    assign w_issue_fire  = issue_valid_o & exec_ready_i;
    assign w_issue_vec   = w_sel & {DEPTH{exec_ready_i}};
    assign push_ready_o  = (r_count != CNT_W'(DEPTH));
    assign w_push_fire   = push_valid_i & push_ready_o;
    assign w_push_write  = w_push_fire & ~w_push_drop;
    assign count_o       = r_count;

    always_comb begin
        w_kill_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill_cnt = w_kill_cnt + CNT_W'(w_kill[i]);
        end
    end

    assign w_count_nxt = r_count + CNT_W'(w_push_write) - CNT_W'(w_issue_fire) - w_kill_cnt;

    // NOTE: state uses non-blocking assignments so later bit writes below override
    // earlier vector writes within the same edge without ordering hazards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_src1_rdy <= '0;
            r_src2_rdy <= '0;
            r_count    <= '0;
            // NOTE: payload arrays are reset too so no X can leak through the select mux.
            for (int i = 0; i < DEPTH; i++) begin
                r_pkt[i] <= '0;
                r_rob[i] <= '0;
                r_age[i] <= '0;
            end
        end else if (flush_i) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            r_valid <= r_valid & ~w_issue_vec & ~w_kill;
            for (int i = 0; i < DEPTH; i++) begin
                r_src1_rdy[i] <= r_src1_rdy[i]
                                 | wake_hit(r_pkt[i].src1_tag, wakeup_valid_i, wakeup_tag_i);
                r_src2_rdy[i] <= r_src2_rdy[i]
                                 | wake_hit(r_pkt[i].src2_tag, wakeup_valid_i, wakeup_tag_i);
            end
            if (w_push_write) begin
                r_valid[w_free_idx]    <= 1'b1;
                r_pkt[w_free_idx]      <= push_pkt_i;
                r_rob[w_free_idx]      <= push_rob_tag_i;
                r_src1_rdy[w_free_idx] <= push_pkt_i.src1_rdy
                                          | wake_hit(push_pkt_i.src1_tag, wakeup_valid_i, wakeup_tag_i);
                r_src2_rdy[w_free_idx] <= push_pkt_i.src2_rdy
                                          | wake_hit(push_pkt_i.src2_tag, wakeup_valid_i, wakeup_tag_i);
                r_age[w_free_idx]      <= r_valid;
                // Stale column bits from the slot's previous occupant must not outrank it.
                for (int i = 0; i < DEPTH; i++) begin
                    r_age[i][w_free_idx] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_age_select.sv
// Scoreboard bench for rs_age_select: directed pushes/wakeups/flush/squash with
// expected issue ROB tags queued at stimulus time and popped by a monitor.
module tb_rs_age_select;
    import rs_age_select_pkg::*;

    localparam int DEPTH = 8;
    localparam int WP    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         flush_i;
    logic                         push_valid_i;
    logic                         push_ready_o;
    rename_pkt_t                  push_pkt_i;
    logic [ROB_TAG_W-1:0]         push_rob_tag_i;
    logic [WP-1:0]                wakeup_valid_i;
    logic [WP-1:0][PREG_W-1:0]    wakeup_tag_i;
    logic [ROB_TAG_W-1:0]         rob_head_i;
    logic                         squash_valid_i;
    logic [ROB_TAG_W-1:0]         squash_rob_tag_i;
    logic                         exec_ready_i;
    logic                         issue_valid_o;
    issue_pkt_t                   issue_pkt_o;
    logic [CW-1:0]                count_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    rs_age_select #(.DEPTH(DEPTH), .WAKE_PORTS(WP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .push_valid_i     (push_valid_i),
        .push_ready_o     (push_ready_o),
        .push_pkt_i       (push_pkt_i),
        .push_rob_tag_i   (push_rob_tag_i),
        .wakeup_valid_i   (wakeup_valid_i),
        .wakeup_tag_i     (wakeup_tag_i),
        .rob_head_i       (rob_head_i),
        .squash_valid_i   (squash_valid_i),
        .squash_rob_tag_i (squash_rob_tag_i),
        .exec_ready_i     (exec_ready_i),
        .issue_valid_o    (issue_valid_o),
        .issue_pkt_o      (issue_pkt_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: an issue handshake is compared against the oldest expected ROB tag.
    always @(negedge clk) begin
        if (rst_n && issue_valid_o && exec_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got rob %0d expected no issue", issue_pkt_o.rob_tag);
            end else begin
                check("issue_rob", 64'(issue_pkt_o.rob_tag), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i          = 1'b0;
        push_valid_i     = 1'b0;
        push_pkt_i       = '0;
        push_rob_tag_i   = '0;
        wakeup_valid_i   = '0;
        wakeup_tag_i     = '0;
        squash_valid_i   = 1'b0;
        squash_rob_tag_i = '0;
        rob_head_i       = '0;
    endtask

    task automatic set_push(input int rob, input int s1, input logic r1, input int s2, input logic r2);
        push_valid_i        = 1'b1;
        push_rob_tag_i      = ROB_TAG_W'(rob);
        push_pkt_i.opcode   = OP_W'(rob + 16);
        push_pkt_i.dst_tag  = PREG_W'(rob + 32);
        push_pkt_i.src1_tag = PREG_W'(s1);
        push_pkt_i.src1_rdy = r1;
        push_pkt_i.src2_tag = PREG_W'(s2);
        push_pkt_i.src2_rdy = r2;
    endtask

    initial begin
        idle();
        rst_n        = 1'b0;
        exec_ready_i = 1'b0;
        #12;
        check("reset_count", 64'(count_o), 0);
        check("reset_push_ready", 64'(push_ready_o), 1);
        check("reset_issue_valid", 64'(issue_valid_o), 0);
        check("reset_issue_pkt", 64'(issue_pkt_o), 0);
        rst_n = 1'b1;
        tick();

        // Fill with 8 ready ops, then drain oldest-first.
        for (int i = 0; i < DEPTH; i++) begin
            set_push(i, 1, 1'b1, 2, 1'b1);
            exp_q.push_back(i);
            tick();
        end
        push_valid_i = 1'b0;
        check("full_count", 64'(count_o), DEPTH);
        check("full_push_ready", 64'(push_ready_o), 0);
        check("full_offer_oldest", 64'(issue_pkt_o.rob_tag), 0);
        exec_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_issue_valid", 64'(issue_valid_o), 1);
            tick();
        end
        check("drain_count", 64'(count_o), 0);
        check("drain_issue_valid_low", 64'(issue_valid_o), 0);

        // Op A waits on tag 12; op B is ready and goes first.
        exec_ready_i = 1'b0;
        set_push(8, 12, 1'b0, 3, 1'b1);
        tick();
        check("a_not_ready", 64'(issue_valid_o), 0);
        set_push(9, 4, 1'b1, 3, 1'b1);
        tick();
        push_valid_i      = 1'b0;
        exec_ready_i      = 1'b1;
        wakeup_valid_i[1] = 1'b1;
        wakeup_tag_i[1]   = 6'd12;
        exp_q.push_back(9);
        exp_q.push_back(8);
        check("b_offered_first", 64'(issue_pkt_o.rob_tag), 9);
        tick();
        wakeup_valid_i = '0;
        check("a_valid_after_wake", 64'(issue_valid_o), 1);
        check("a_offered", 64'(issue_pkt_o.rob_tag), 8);
        tick();
        check("ab_count", 64'(count_o), 0);

        // Push bypass: src2 tag 5 woken in the push cycle.
        set_push(3, 7, 1'b1, 5, 1'b0);
        wakeup_valid_i[0] = 1'b1;
        wakeup_tag_i[0]   = 6'd5;
        exp_q.push_back(3);
        tick();
        push_valid_i   = 1'b0;
        wakeup_valid_i = '0;
        check("bypass_issue_valid", 64'(issue_valid_o), 1);
        tick();
        check("bypass_count", 64'(count_o), 0);

        // Physical tag 0 never wakes an entry.
        set_push(4, 0, 1'b0, 9, 1'b1);
        wakeup_valid_i = 2'b11;
        wakeup_tag_i   = '0;
        tick();
        push_valid_i   = 1'b0;
        wakeup_valid_i = '0;
        tick();
        check("tag0_no_wake", 64'(issue_valid_o), 0);
        check("tag0_count", 64'(count_o), 1);

        // Flush during an issue with a push offered.
        exec_ready_i = 1'b0;
        set_push(5, 1, 1'b1, 2, 1'b1);
        tick();
        check("pre_flush_count", 64'(count_o), 2);
        check("pre_flush_valid", 64'(issue_valid_o), 1);
        flush_i      = 1'b1;
        exec_ready_i = 1'b1;
        set_push(6, 1, 1'b1, 2, 1'b1);
        tick();
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        check("flush_count", 64'(count_o), 0);
        check("flush_issue_valid", 64'(issue_valid_o), 0);
        check("flush_push_ready", 64'(push_ready_o), 1);

        // Full RS with push and issue in the same cycle: push is refused.
        exec_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(i, 1, 1'b1, 2, 1'b1);
            exp_q.push_back(i);
            tick();
        end
        set_push(9, 1, 1'b1, 2, 1'b1);
        exec_ready_i = 1'b1;
        check("fill_push_ready", 64'(push_ready_o), 0);
        tick();
        push_valid_i = 1'b0;
        check("fill_count_after", 64'(count_o), DEPTH - 1);
        check("fill_push_ready_after", 64'(push_ready_o), 1);
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check("fill_drain_count", 64'(count_o), 0);

`ifdef RS_SQUASH_EN
        // Squash around the ROB wrap point: head 14, branch 15.
        exec_ready_i = 1'b0;
        rob_head_i   = 4'd14;
        for (int i = 0; i < 4; i++) begin
            set_push((14 + i) % 16, 1, 1'b1, 2, 1'b1);
            tick();
        end
        check("sq_pre_count", 64'(count_o), 4);
        squash_valid_i   = 1'b1;
        squash_rob_tag_i = 4'd15;
        set_push(2, 1, 1'b1, 2, 1'b1);
        check("sq_push_ready", 64'(push_ready_o), 1);
        check("sq_offer", 64'(issue_pkt_o.rob_tag), 14);
        tick();
        squash_valid_i = 1'b0;
        push_valid_i   = 1'b0;
        check("sq_count", 64'(count_o), 2);
        exp_q.push_back(14);
        exp_q.push_back(15);
        exec_ready_i = 1'b1;
        tick();
        tick();
        check("sq_drain_count", 64'(count_o), 0);
        rob_head_i = '0;
`endif

        // Asynchronous reset mid-operation.
        exec_ready_i = 1'b0;
        set_push(7, 1, 1'b1, 2, 1'b1);
        tick();
        push_valid_i = 1'b0;
        check("pre_async_count", 64'(count_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", 64'(count_o), 0);
        check("async_issue_valid", 64'(issue_valid_o), 0);
        check("async_push_ready", 64'(push_ready_o), 1);
        rst_n = 1'b1;
        tick();
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs_age_select.md
# rs_age_select

Parametrised reservation station, successor to the fixed depth-8 branch RS wrapper. It holds renamed micro-ops until their source operands are ready and accepts wakeups on several broadcast ports at once. Each cycle it issues the oldest ready entry to its execution unit and supports a selective squash of wrong-path entries after a branch mispredict. It sits between rename/dispatch and a single execution pipe (BRU, ALU or LSU) in the out-of-order core.

## Interface
- DEPTH, 8: number of entries; ≥2.
- WAKE_PORTS, 2: number of parallel wakeup broadcast ports; ≥1.
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived; do not override).
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  full pipeline flush; clears every entry.
- push_valid_i  in  1  dispatch offers an entry.
- push_ready_o  out  1  at least one free entry.
- push_pkt_i  in  rename_pkt_t  renamed micro-op, carrying source physical tags and their ready bits.
- push_rob_tag_i  in  ROB_TAG_W  ROB tag of the pushed op.
- wakeup_valid_i  in  WAKE_PORTS  per-port wakeup strobe.
- wakeup_tag_i  in  WAKE_PORTS x PREG_W  per-port destination physical tag.
- rob_head_i  in  ROB_TAG_W  current ROB head, used as the age reference for squash.
- squash_valid_i  in  1  mispredict squash request (RS_SQUASH_EN only).
- squash_rob_tag_i  in  ROB_TAG_W  tag of the mispredicting branch (RS_SQUASH_EN only).
- exec_ready_i  in  1  execution unit accepts an issue.
- issue_valid_o  out  1  an entry is being offered for issue.
- issue_pkt_o  out  issue_pkt_t  packet built from the selected entry plus its ROB tag.
- count_o  out  CNT_W  occupied entries.

## Operation
- Each entry holds: valid, stored packet, ROB tag, src1_rdy, src2_rdy.
- Push fires when push_valid_i & push_ready_o. The entry goes to the lowest-index free slot.
- Source ready bits are captured as the packet's ready bits OR'd with a same-cycle match on any wakeup port (push bypass).
- Wakeup: for each valid entry, any port p with wakeup_valid_i[p] and a matching wakeup_tag_i[p] sets the matching src_rdy bit. Multiple ports may hit one entry in the same cycle. Physical tag 0 never wakes anything.
- Age: a DEPTH×DEPTH age matrix. On push, row[new] is set to "older than me" for every currently valid entry.
- Select: among valid entries with both sources ready, pick the one that no other ready entry is older than.
- Issue fires when issue_valid_o & exec_ready_i. The selected entry is freed at that edge.
- Squash (RS_SQUASH_EN): an entry is younger when (tag − rob_head_i) mod 2^ROB_TAG_W > (squash_rob_tag_i − rob_head_i) mod 2^ROB_TAG_W.
  - Younger entries are invalidated. The branch itself and older entries are kept.
  - A same-cycle push whose tag is younger is dropped. push_ready_o is unaffected.
- Priority: flush_i > squash > issue/push/wakeup.

## Timing
- Reset: all entries invalid, age matrix cleared, issue_valid_o=0, issue_pkt_o='0, push_ready_o=1, count_o=0.
- push_ready_o = (count_o != DEPTH), computed from registered state only. A same-cycle issue does not free a slot for a same-cycle push.
- Minimum push-to-issue latency is 1 cycle: an op pushed ready at edge N can have issue_valid_o high in the cycle after edge N.
- A wakeup on a stored entry makes it eligible in the next cycle. There is no same-cycle wakeup-to-issue path.
- issue_valid_o and issue_pkt_o are combinational from registered state. Under RS_SQUASH_EN they are also masked so that an entry being squashed this cycle is never offered.
- issue_pkt_o is stable while issue_valid_o=1 and exec_ready_i=0, unless an older entry becomes ready. Reselection is permitted; the execution unit must not rely on stability.
- count_o update: +1 on push, −1 on issue, minus the squashed count. A push and an issue in the same cycle leave it unchanged. Flush forces 0 at the next edge.
- If rst_n is asserted mid-operation, all state clears immediately (asynchronously).

## Configuration
- RS_SQUASH_EN defined: selective squash logic, rob_head_i comparison and issue masking are present.
- RS_SQUASH_EN undefined:
  - squash_valid_i and squash_rob_tag_i remain as ports but are ignored.
  - rob_head_i is unused.
  - Mispredict recovery is by flush_i only.

## Test plan
- Push 8 ready ops with ROB tags 0..7, exec_ready_i=1 → issue tags in order 0,1,...,7 over 8 consecutive cycles. push_ready_o=0 after the 8th push, with no issue yet.
- Push op A (src1 tag 12, not ready), then op B (ready). Wakeup port 1 tag 12 → B issues first. A's issue_valid_o rises the cycle after the wakeup edge.
- Push an op with src2 tag 5 while wakeup_valid_i[0]=1 and wakeup_tag_i[0]=5 in the same cycle → op issues on the next cycle.
- Fill all DEPTH entries, then assert push_valid_i and issue simultaneously → push rejected (push_ready_o=0) and count_o=DEPTH−1 after the edge.
- RS_SQUASH_EN: rob_head_i=14, entries with tags 14,15,0,1, squash_rob_tag_i=15 → entries with tags 0 and 1 are invalidated, count_o=2, and the entry with tag 14 issues first.
- Assert flush_i while an entry is issuing and a push is offered → the next cycle has count_o=0, issue_valid_o=0 and push_ready_o=1.
